sort_run_controller: RTL and testbench

Run sequencer for the RISC-V bubble-sort datapath. Holds the core in reset and takes the data-memory port to load an N-element array from a host stream. Then releases the core and waits for it to reach the halt PC. Finally re-takes the memory, streams the results back to the host and flags whether they are sorted (signed ascending).

---
 rtl/sort_run_controller.sv | 214 +++++++++++++++++++++
 tb/tb_sort_run_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_run_controller.sv
// sort_run_controller
//   Run sequencer for the RISC-V bubble-sort datapath. Holds the core in reset
//   while an N_ELEM-element array is streamed from the host into data memory.
//   It then releases the core and waits for pc_out_i to sit at HALT_PC for
//   HALT_HOLD consecutive cycles. After that it takes the memory back, streams
//   the results to the host and flags whether they are signed non-decreasing.
//
//   Optional feature: define SORT_WATCHDOG_EN to abort RUN once cycle_count
//   reaches MAX_CYCLES. The abort sets timeout_o, and the readback still runs.
//   Without the macro, timeout_o stays 0.
//
// Ports
//   clk_i, reset_i        clock (rising edge), async active-high reset
//   start_i               run request pulse, honoured in IDLE/DONE only
//   load_valid_i/_data_i  host element stream; load_ready_o high in LOAD
//   pc_out_i              core program counter
//   core_reset_o          reset to the core
//   mem_sel_o             1 = controller owns the data-memory port
//   mem_we_o/_addr_o/_wdata_o, mem_rdata_i   controller memory port
//   result_valid_o/_data_o                   readback stream
//   busy_o, done_o, sorted_ok_o, timeout_o, cycle_count_o   status
module sort_run_controller #(
  parameter int unsigned N_ELEM     = 8,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter logic [63:0] HALT_PC    = 64'h80,
  parameter int unsigned HALT_HOLD  = 2,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        load_valid_i,
  input  logic [63:0] load_data_i,
  output logic        load_ready_o,
  input  logic [63:0] pc_out_i,
  output logic        core_reset_o,
  output logic        mem_sel_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  output logic        result_valid_o,
  output logic [63:0] result_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        sorted_ok_o,
  output logic        timeout_o,
  output logic [31:0] cycle_count_o
);

  // idx must reach N_ELEM: READ spends one extra cycle presenting the last element.
  localparam int unsigned IdxW  = $clog2(N_ELEM + 1);
  localparam int unsigned HaltW = $clog2(HALT_HOLD + 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N_ELEM - 1);
  localparam logic [IdxW-1:0]  EndIdx   = IdxW'(N_ELEM);
  localparam logic [HaltW-1:0] HaltHold = HaltW'(HALT_HOLD);
  localparam logic [31:0]      WdLimit  = 32'(MAX_CYCLES);

`ifdef SORT_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StRead, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [HaltW-1:0] halt_q, halt_d;
  logic [31:0]      cycle_count_q, cycle_count_d;
  logic             core_reset_q, core_reset_d;
  logic             mem_sel_q, mem_sel_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             sorted_ok_q, sorted_ok_d;
  logic             result_valid_q, result_valid_d;
  logic [63:0]      result_data_q, result_data_d;

  logic [HaltW-1:0] halt_inc;
  logic             halt_hit;
  logic             wd_hit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      halt_q         <= '0;
      cycle_count_q  <= '0;
      core_reset_q   <= 1'b1;
      mem_sel_q      <= 1'b1;
      timeout_q      <= 1'b0;
      done_q         <= 1'b0;
      sorted_ok_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      halt_q         <= halt_d;
      cycle_count_q  <= cycle_count_d;
      core_reset_q   <= core_reset_d;
      mem_sel_q      <= mem_sel_d;
      timeout_q      <= timeout_d;
      done_q         <= done_d;
      sorted_ok_q    <= sorted_ok_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    halt_d         = halt_q;
    cycle_count_d  = cycle_count_q;
    core_reset_d   = core_reset_q;
    mem_sel_d      = mem_sel_q;
    timeout_d      = timeout_q;
    done_d         = done_q;
    sorted_ok_d    = sorted_ok_q;
    result_valid_d = 1'b0;
    result_data_d  = result_data_q;
    halt_inc       = halt_q + 1'b1;
    halt_hit       = 1'b0;
    wd_hit         = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d       = StLoad;
          idx_d         = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          done_d        = 1'b0;
          sorted_ok_d   = 1'b1;
        end
      end
      StLoad: begin
        if (load_valid_i) begin
          if (idx_q == LastIdx) begin
            state_d      = StRun;
            idx_d        = '0;
            halt_d       = '0;
            core_reset_d = 1'b0;
            mem_sel_d    = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        wd_hit = WdEn && (cycle_count_d == WdLimit);
        if (pc_out_i == HALT_PC) begin
          halt_hit = (halt_inc == HaltHold);
          halt_d   = halt_inc;
        end else begin
          halt_d = '0;
        end
        if (halt_hit || wd_hit) begin
          state_d      = StRead;
          idx_d        = '0;
          halt_d       = '0;
          core_reset_d = 1'b1;
          mem_sel_d    = 1'b1;
          if (wd_hit) begin
            timeout_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (idx_q != EndIdx) begin
          result_valid_d = 1'b1;
          result_data_d  = mem_rdata_i;
          idx_d          = idx_q + 1'b1;
          // result_data_q still holds the previous element here.
          if ((idx_q != '0) && ($signed(result_data_q) > $signed(mem_rdata_i))) begin
            sorted_ok_d = 1'b0;
          end
        end else begin
          state_d = StDone;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_ready_o   = (state_q == StLoad);
    mem_we_o       = (state_q == StLoad) && load_valid_i;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    if ((state_q == StLoad) || (state_q == StRead)) begin
      mem_addr_o = BASE_ADDR + 64'({idx_q, 3'b000});
    end
    if (state_q == StLoad) begin
      mem_wdata_o = load_data_i;
    end
    busy_o         = (state_q == StLoad) || (state_q == StRun) || (state_q == StRead);
    core_reset_o   = core_reset_q;
    mem_sel_o      = mem_sel_q;
    result_valid_o = result_valid_q;
    result_data_o  = result_data_q;
    done_o         = done_q;
    sorted_ok_o    = sorted_ok_q;
    timeout_o      = timeout_q;
    cycle_count_o  = cycle_count_q;
  end

endmodule

// File: tb/tb_sort_run_controller.sv
// Directed bench for sort_run_controller with a 16-entry data memory and a
// scripted core that writes the sorted array while it owns the port.
module tb_sort_run_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        load_valid;
  logic [63:0] load_data;
  logic        load_ready;
  logic [63:0] pc_out;
  logic        core_reset;
  logic        mem_sel;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        result_valid;
  logic [63:0] result_data;
  logic        busy;
  logic        done;
  logic        sorted_ok;
  logic        timeout;
  logic [31:0] cycle_count;

  logic        core_we;
  logic [3:0]  core_idx;
  logic [63:0] core_wdata;
  logic [63:0] mem [16];

  logic [63:0] load_vec   [8];
  logic [63:0] sorted_vec [8];

  int checks = 0;
  int errors = 0;

  sort_run_controller #(
    .N_ELEM    (8),
    .BASE_ADDR (64'h0),
    .HALT_PC   (64'h80),
    .HALT_HOLD (2),
    .MAX_CYCLES(16)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .load_valid_i  (load_valid),
    .load_data_i   (load_data),
    .load_ready_o  (load_ready),
    .pc_out_i      (pc_out),
    .core_reset_o  (core_reset),
    .mem_sel_o     (mem_sel),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .result_valid_o(result_valid),
    .result_data_o (result_data),
    .busy_o        (busy),
    .done_o        (done),
    .sorted_ok_o   (sorted_ok),
    .timeout_o     (timeout),
    .cycle_count_o (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_we) mem[mem_addr[6:3]] <= mem_wdata;
    end else if (core_we) begin
      mem[core_idx] <= core_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[6:3]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_load_ready", load_ready, 1);
    chk("start_done_clr", done, 0);
    chk("start_sorted_set", sorted_ok, 1);
    chk("start_cc_clr", cycle_count, 0);
    chk("start_timeout_clr", timeout, 0);
  endtask

  task automatic load_elem(input int i, input logic [63:0] d);
    load_valid = 1'b1;
    load_data  = d;
    #1;
    chk("load_ready", load_ready, 1);
    chk("load_we", mem_we, 1);
    chk("load_addr", mem_addr, 64'(8 * i));
    chk("load_wdata", mem_wdata, d);
    chk("load_core_reset", core_reset, 1);
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 8; i++) load_elem(i, load_vec[i]);
    chk("run_core_reset", core_reset, 0);
    chk("run_mem_sel", mem_sel, 0);
    chk("run_busy", busy, 1);
    chk("run_load_ready", load_ready, 0);
  endtask

  task automatic readback(input bit use_sorted);
    chk("read_mem_sel", mem_sel, 1);
    chk("read_core_reset", core_reset, 1);
    chk("read_first_valid", result_valid, 0);
    for (int k = 0; k < 8; k++) begin
      chk("read_addr", mem_addr, 64'(8 * k));
      cyc();
      chk("read_valid", result_valid, 1);
      chk("read_data", result_data, use_sorted ? sorted_vec[k] : load_vec[k]);
      chk("read_busy", busy, 1);
    end
    cyc();
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", result_valid, 0);
    chk("done_core_reset", core_reset, 1);
    chk("done_mem_sel", mem_sel, 1);
  endtask

  initial begin
    load_vec   = '{64'd5, -64'sd3, 64'd9, 64'd0, 64'd2, 64'd7, -64'sd1, 64'd4};
    sorted_vec = '{-64'sd3, -64'sd1, 64'd0, 64'd2, 64'd4, 64'd5, 64'd7, 64'd9};
    reset      = 1'b1;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    pc_out     = '0;
    core_we    = 1'b0;
    core_idx   = '0;
    core_wdata = '0;
    cyc();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_mem_sel", mem_sel, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sorted_ok", sorted_ok, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_cycle_count", cycle_count, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Reset asserted mid-LOAD after three elements.
    do_start();
    for (int i = 0; i < 3; i++) load_elem(i, load_vec[i]);
    load_valid = 1'b1;
    reset      = 1'b1;
    #1;
    chk("midload_core_reset", core_reset, 1);
    chk("midload_mem_sel", mem_sel, 1);
    chk("midload_load_ready", load_ready, 0);
    chk("midload_we", mem_we, 0);
    chk("midload_busy", busy, 0);
    chk("midload_addr", mem_addr, 0);
    load_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    // Full run: the core sorts, a one-cycle halt glitch, then a real halt.
    do_start();
    load_all();
    for (int i = 0; i < 8; i++) chk("mem_loaded", mem[i], load_vec[i]);
    for (int i = 0; i < 8; i++) begin
      core_we    = 1'b1;
      core_idx   = 4'(i);
      core_wdata = sorted_vec[i];
      cyc();
    end
    core_we = 1'b0;
    pc_out  = 64'h80;
    cyc();
    pc_out = 64'h10;
    cyc();
    chk("glitch_mem_sel", mem_sel, 0);
    chk("glitch_core_reset", core_reset, 0);
    chk("glitch_cc", cycle_count, 10);
    pc_out = 64'h80;
    cyc();
    chk("halt1_mem_sel", mem_sel, 0);
    cyc();
    chk("halt_cc", cycle_count, 12);
    pc_out = 64'h0;
    readback(1'b1);
    chk("sorted_ok_set", sorted_ok, 1);
    chk("sorted_timeout", timeout, 0);
    chk("sorted_cc_hold", cycle_count, 12);

    // Unsorted run: core leaves memory alone, then halts at once.
    do_start();
    load_all();
    pc_out = 64'h80;
    cyc();
    cyc();
    chk("unsorted_cc", cycle_count, 2);
    pc_out = 64'h0;
    readback(1'b0);
    chk("unsorted_ok_clr", sorted_ok, 0);

    // PC never halts; a start pulse in RUN must be ignored.
    do_start();
    load_all();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("ign_start_ready", load_ready, 0);
    chk("ign_start_mem_sel", mem_sel, 0);
    chk("ign_start_cc", cycle_count, 5);
`ifdef SORT_WATCHDOG_EN
    for (int i = 0; i < 10; i++) cyc();
    chk("wd_pre_mem_sel", mem_sel, 0);
    chk("wd_pre_timeout", timeout, 0);
    cyc();
    chk("wd_timeout", timeout, 1);
    chk("wd_cc", cycle_count, 16);
    chk("wd_busy", busy, 1);
    readback(1'b0);
    chk("wd_done_timeout", timeout, 1);
    chk("wd_sorted_ok", sorted_ok, 0);
`else
    for (int i = 0; i < 15; i++) cyc();
    chk("nowd_mem_sel", mem_sel, 0);
    chk("nowd_core_reset", core_reset, 0);
    chk("nowd_busy", busy, 1);
    chk("nowd_timeout", timeout, 0);
    chk("nowd_cc", cycle_count, 20);
`endif

    // Asynchronous reset with the run in flight (or just finished).
    reset = 1'b1;
    #1;
    chk("final_rst_core_reset", core_reset, 1);
    chk("final_rst_mem_sel", mem_sel, 1);
    chk("final_rst_busy", busy, 0);
    chk("final_rst_done", done, 0);
    chk("final_rst_timeout", timeout, 0);
    chk("final_rst_cc", cycle_count, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
